// File: rtl/cmos_pattern_src_pkg.sv
// Shared types, colour-bar table and geometry helpers
// for the synthetic DVP pattern source.
package cmos_pattern_src_pkg;

   typedef enum logic [1:0] {
      MODE_BARS  = 2'd0,
      MODE_RAMP  = 2'd1,
      MODE_CHECK = 2'd2,
      MODE_SOLID = 2'd3
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   // Element 0 is the leftmost bar on screen.
   localparam logic [7:0][15:0] BAR_RGB = {
      16'h0000, 16'h001F, 16'hF800, 16'hF81F,
      16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
   };

   function automatic int line_len(
      input int h_active,
      input int h_blank
   );
      return 2 * h_active + h_blank;
   endfunction

   function automatic int frame_lines(
      input int v_sync,
      input int v_bp,
      input int v_active,
      input int v_fp
   );
      return v_sync + v_bp + v_active + v_fp;
   endfunction

   function automatic int cnt_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/cmos_pattern_pix.sv
// Test-pattern generator: maps pixel coordinates to RGB565.
// Only the colour-bar index is stateful.
module cmos_pattern_pix
   import cmos_pattern_src_pkg::*;
#(
   parameter int H_ACTIVE = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        bar_clr_i,
   input  logic        bar_adv_i,
   input  logic [15:0] x_i,
   input  logic [15:0] y_i,
   input  logic [15:0] frame_cnt_i,
   input  mode_e       mode_i,
   input  logic [15:0] solid_i,
   output logic [15:0] pix_o
);

   localparam int BAR_W = H_ACTIVE / 8;
   localparam int RW    = cnt_w(BAR_W);
   localparam logic [RW-1:0] REM_LOAD = RW'(BAR_W - 1);

   logic [2:0]    bar_idx_q, bar_idx_d;
   logic [RW-1:0] bar_rem_q, bar_rem_d;

   // bar_rem counts the pixels left in the current bar
   always_comb begin
      bar_idx_d = bar_idx_q;
      bar_rem_d = bar_rem_q;
      if (bar_clr_i) begin
         bar_idx_d = 3'd0;
         bar_rem_d = REM_LOAD;
      end else if (bar_adv_i) begin
         if (bar_rem_q == '0) begin
            bar_idx_d = bar_idx_q + 3'd1;
            bar_rem_d = REM_LOAD;
         end else begin
            bar_rem_d = bar_rem_q - RW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bar_idx_q <= 3'd0;
         bar_rem_q <= REM_LOAD;
      end else begin
         bar_idx_q <= bar_idx_d;
         bar_rem_q <= bar_rem_d;
      end
   end

   always_comb begin
      pix_o = 16'h0000;
      case (mode_i)
         MODE_BARS:  pix_o = BAR_RGB[bar_idx_q];
         MODE_RAMP:  pix_o = x_i + y_i + frame_cnt_i;
         MODE_CHECK: pix_o = (x_i[5] ^ y_i[5]) ? 16'hFFFF : 16'h0000;
         MODE_SOLID: pix_o = solid_i;
         default:    pix_o = 16'h0000;
      endcase
   end

endmodule

// File: rtl/cmos_pattern_src.sv
// Synthetic OV5640-style DVP transmitter: frame timing,
// run/idle control and registered vsync/href/data pins.
module cmos_pattern_src
   import cmos_pattern_src_pkg::*;
#(
   parameter int H_ACTIVE = 1024,
   parameter int V_ACTIVE = 768,
   parameter int H_BLANK  = 64,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 16,
   parameter int V_FP     = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [1:0]  mode,
   input  logic [15:0] solid_color,
   output logic        cam_vsync,
   output logic        cam_href,
   output logic [7:0]  cam_data,
   output logic [15:0] frame_cnt,
   output logic        busy
);

   localparam int LINE_LEN    = line_len(H_ACTIVE, H_BLANK);
   localparam int FRAME_LINES =
      frame_lines(V_SYNC, V_BP, V_ACTIVE, V_FP);
   localparam int HW     = cnt_w(LINE_LEN);
   localparam int VW     = cnt_w(FRAME_LINES);
   localparam int V_ACT0 = V_SYNC + V_BP;
   localparam int V_ACT1 = V_ACT0 + V_ACTIVE;
   localparam int H_ACTB = 2 * H_ACTIVE;
   localparam logic [HW-1:0] H_LAST = HW'(LINE_LEN - 1);
   localparam logic [VW-1:0] V_LAST = VW'(FRAME_LINES - 1);

   state_e        state_q, state_d;
   logic [HW-1:0] h_cnt_q, h_cnt_d;
   logic [VW-1:0] v_cnt_q, v_cnt_d;
   logic [15:0]   frame_cnt_q, frame_cnt_d;
   mode_e         mode_q, mode_d;
   logic [15:0]   solid_q, solid_d;
   logic          vsync_q, vsync_d;
   logic          href_q, href_d;
   logic [7:0]    data_q, data_d;

   logic          run;
   logic          end_line;
   logic          end_frame;
   logic          h_act;
   logic          bar_clr;
   logic          bar_adv;
   logic [15:0]   pix_x;
   logic [15:0]   pix_y;
   logic [15:0]   pix;

   assign run       = (state_q == ST_RUN);
   assign end_line  = (h_cnt_q == H_LAST);
   assign end_frame = end_line && (v_cnt_q == V_LAST);
   assign h_act     = (int'(h_cnt_q) < H_ACTB);

   always_comb begin
      state_d     = state_q;
      h_cnt_d     = h_cnt_q;
      v_cnt_d     = v_cnt_q;
      frame_cnt_d = frame_cnt_q;
      mode_d      = mode_q;
      solid_d     = solid_q;
      case (state_q)
         ST_IDLE: begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (en) begin
               state_d = ST_RUN;
               mode_d  = mode_e'(mode);
               solid_d = solid_color;
            end
         end
         ST_RUN: begin
            if (end_line) begin
               h_cnt_d = '0;
               v_cnt_d = end_frame ? '0 : v_cnt_q + VW'(1);
            end else begin
               h_cnt_d = h_cnt_q + HW'(1);
            end
            // en is only honoured at frame boundaries
            if (end_frame) begin
               frame_cnt_d = frame_cnt_q + 16'd1;
               if (en) begin
                  mode_d  = mode_e'(mode);
                  solid_d = solid_color;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign pix_x   = 16'(h_cnt_q >> 1);
   assign pix_y   = 16'(v_cnt_q) - 16'(V_ACT0);
   assign bar_clr = !run || end_line;
   assign bar_adv = h_cnt_q[0] && h_act;

   cmos_pattern_pix #(
      .H_ACTIVE (H_ACTIVE)
   ) u_pix (
      .clk         (clk),
      .rst_n       (rst_n),
      .bar_clr_i   (bar_clr),
      .bar_adv_i   (bar_adv),
      .x_i         (pix_x),
      .y_i         (pix_y),
      .frame_cnt_i (frame_cnt_q),
      .mode_i      (mode_q),
      .solid_i     (solid_q),
      .pix_o       (pix)
   );

   always_comb begin
      vsync_d = run && (int'(v_cnt_q) < V_SYNC);
      href_d  = run && h_act
             && (int'(v_cnt_q) >= V_ACT0)
             && (int'(v_cnt_q) < V_ACT1);
      data_d  = 8'h00;
      if (href_d) begin
         data_d = h_cnt_q[0] ? pix[7:0] : pix[15:8];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= 16'd0;
         mode_q      <= MODE_BARS;
         solid_q     <= 16'h0000;
         vsync_q     <= 1'b0;
         href_q      <= 1'b0;
         data_q      <= 8'h00;
      end else begin
         state_q     <= state_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         mode_q      <= mode_d;
         solid_q     <= solid_d;
         vsync_q     <= vsync_d;
         href_q      <= href_d;
         data_q      <= data_d;
      end
   end

   assign cam_vsync = vsync_q;
   assign cam_href  = href_q;
   assign cam_data  = data_q;
   assign frame_cnt = frame_cnt_q;
   assign busy      = run;

endmodule

// File: tb/tb_cmos_pattern_src.sv
// Bench for cmos_pattern_src: frame-time reference model
// compared every cycle, plus directed literal checks.
module tb_cmos_pattern_src;

   localparam int HA    = 16;
   localparam int VA    = 4;
   localparam int HB    = 4;
   localparam int VS    = 1;
   localparam int VBP   = 1;
   localparam int VFP   = 1;
   localparam int LL    = 2 * HA + HB;
   localparam int FL    = VS + VBP + VA + VFP;
   localparam int FRAME = LL * FL;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic [1:0]  mode = 2'd0;
   logic [15:0] solid_color = 16'h0000;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic [15:0] frame_cnt;
   logic        busy;

   cmos_pattern_src #(
      .H_ACTIVE (HA),
      .V_ACTIVE (VA),
      .H_BLANK  (HB),
      .V_SYNC   (VS),
      .V_BP     (VBP),
      .V_FP     (VFP)
   ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .mode        (mode),
      .solid_color (solid_color),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_data    (cam_data),
      .frame_cnt   (frame_cnt),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Model: a frame is FRAME clocks, position t = line*LL + col
   bit          m_run;
   int          m_t;
   logic [15:0] m_fc;
   logic [1:0]  m_mode;
   logic [15:0] m_solid;
   logic        e_vs, e_href, e_busy;
   logic [7:0]  e_data;
   logic [15:0] e_fc;

   function automatic logic [15:0] exp_pix(
      input logic [1:0] md, input int x, input int y,
      input logic [15:0] fc, input logic [15:0] sc);
      logic [15:0] bars [8];
      bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
               16'hF81F, 16'hF800, 16'h001F, 16'h0000};
      case (md)
         2'd0: return bars[x / (HA / 8)];
         2'd1: return 16'(x + y + int'(fc));
         2'd2: return (((x / 32) + (y / 32)) % 2 == 1)
                      ? 16'hFFFF : 16'h0000;
         default: return sc;
      endcase
   endfunction

   function automatic bit exp_vs(input bit run, input int t);
      return run && (t / LL) < VS;
   endfunction

   function automatic bit exp_href(input bit run, input int t);
      int ln = t / LL;
      return run && ln >= VS + VBP && ln < VS + VBP + VA
             && (t % LL) < 2 * HA;
   endfunction

   function automatic logic [7:0] exp_byte(
      input bit run, input int t, input logic [1:0] md,
      input logic [15:0] fc, input logic [15:0] sc);
      logic [15:0] p;
      if (!exp_href(run, t)) return 8'h00;
      p = exp_pix(md, (t % LL) / 2, t / LL - VS - VBP, fc, sc);
      return ((t % LL) % 2 == 0) ? p[15:8] : p[7:0];
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_run <= 1'b0; m_t <= 0; m_fc <= 16'd0;
         m_mode <= 2'd0; m_solid <= 16'h0000;
         e_vs <= 1'b0; e_href <= 1'b0; e_data <= 8'h00;
         e_fc <= 16'd0; e_busy <= 1'b0;
      end else begin
         e_vs   <= exp_vs(m_run, m_t);
         e_href <= exp_href(m_run, m_t);
         e_data <= exp_byte(m_run, m_t, m_mode, m_fc, m_solid);
         if (!m_run) begin
            e_fc   <= m_fc;
            e_busy <= en;
            if (en) begin
               m_run <= 1'b1; m_t <= 0;
               m_mode <= mode; m_solid <= solid_color;
            end
         end else if (m_t == FRAME - 1) begin
            e_fc   <= m_fc + 16'd1;
            e_busy <= en;
            m_fc <= m_fc + 16'd1;
            m_t  <= 0;
            if (en) begin
               m_mode <= mode; m_solid <= solid_color;
            end else begin
               m_run <= 1'b0;
            end
         end else begin
            e_fc   <= m_fc;
            e_busy <= 1'b1;
            m_t    <= m_t + 1;
         end
      end
   end

   int          vectors = 0;
   int          miscompares = 0;
   bit          done = 0;
   int          vs_total = 0;
   int          nz_idle = 0;
   int          hi_run = 0;
   int          lo_run = 0;
   bit          prev_href = 0;
   bit          seen_fall = 0;
   int          widths [$];
   int          gaps [$];
   logic [7:0]  cap [$];

   task automatic check(input string name,
                        input logic [63:0] act,
                        input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_fc(input logic [15:0] v, input int lim);
      int n = 0;
      while (frame_cnt !== v && n < lim) begin
         tick(1);
         n++;
      end
      check("wait frame_cnt", 64'(frame_cnt), 64'(v));
   endtask

   task automatic wait_idle(input int lim, output int n);
      n = 0;
      while (busy !== 1'b0 && n < lim) begin
         tick(1);
         n++;
      end
      check("wait idle", 64'(busy), 64'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check("reset outs",
            64'({cam_vsync, cam_href, cam_data, frame_cnt, busy}),
            64'd0);
      tick(2);
      rst_n = 1'b1;
   endtask

   task automatic monitor();
      while (!done) begin
         @(negedge clk);
         vectors++;
         if ({cam_vsync, cam_href, cam_data, frame_cnt, busy} !==
             {e_vs, e_href, e_data, e_fc, e_busy}) begin
            miscompares++;
            $display("FAIL cycle @%0t: vs %b/%b href %b/%b data %h/%h fc %0d/%0d busy %b/%b",
                     $time, cam_vsync, e_vs, cam_href, e_href,
                     cam_data, e_data, frame_cnt, e_fc, busy, e_busy);
         end
         if (cam_vsync) vs_total++;
         if (cam_href) begin
            if (!prev_href) begin
               if (seen_fall) gaps.push_back(lo_run);
               hi_run = 0;
            end
            hi_run++;
            cap.push_back(cam_data);
         end else begin
            if (prev_href) begin
               widths.push_back(hi_run);
               seen_fall = 1;
               lo_run = 0;
            end
            lo_run++;
            if (cam_data != 8'h00) nz_idle++;
         end
         prev_href = cam_href;
      end
   endtask

   task automatic stimulus();
      int vb, wb, cb, cb1, cb3, n, bad;
      tick(3);
      do_reset();
      tick(2);

      // single-frame colour bars from a one-cycle en pulse
      vb = vs_total; wb = widths.size(); cb = cap.size();
      mode = 2'd0; en = 1'b1;
      tick(1);
      en = 1'b0;
      tick(251);
      check("fc before end", 64'(frame_cnt), 64'd0);
      check("busy before end", 64'(busy), 64'd1);
      tick(1);
      check("fc after frame", 64'(frame_cnt), 64'd1);
      check("busy after frame", 64'(busy), 64'd0);
      tick(4);
      check("vsync clocks", 64'(vs_total - vb), 64'd36);
      check("href pulses", 64'(widths.size() - wb), 64'd4);
      bad = 0;
      for (int i = wb; i < widths.size(); i++)
         if (widths[i] != 32) bad++;
      check("href widths", 64'(bad), 64'd0);
      bad = 0;
      for (int i = gaps.size() - 3; i < gaps.size(); i++)
         if (i < 0 || gaps[i] != 4) bad++;
      check("href gaps", 64'(bad), 64'd0);
      check("bar bytes", 64'(cap.size() - cb), 64'd128);
      check("bar first", {16'h0, cap[cb], cap[cb+1], cap[cb+2],
            cap[cb+3], cap[cb+4], cap[cb+5]}, 64'hFFFF_FFFF_FFE0);
      check("bar last", 64'({cap[cb+126], cap[cb+127]}), 64'h0);

      // solid colour, inputs changed right after the latch
      cb = cap.size();
      mode = 2'd3; solid_color = 16'hA55A; en = 1'b1;
      tick(1);
      en = 1'b0; mode = 2'd0; solid_color = 16'h1234;
      wait_idle(400, n);
      check("solid bytes", 64'(cap.size() - cb), 64'd128);
      bad = 0;
      for (int i = cb; i + 1 < cap.size(); i += 2)
         if (cap[i] != 8'hA5 || cap[i+1] != 8'h5A) bad++;
      check("solid pairs", 64'(bad), 64'd0);

      // en dropped at clock 100 of the frame
      do_reset();
      mode = 2'd0; en = 1'b1;
      tick(101);
      en = 1'b0;
      wait_idle(400, n);
      check("frame end clock", 64'(n), 64'd152);
      check("fc after stop", 64'(frame_cnt), 64'd1);
      vb = vs_total;
      tick(300);
      check("no more vsync", 64'(vs_total - vb), 64'd0);
      check("idle pins",
            64'({cam_vsync, cam_href, cam_data, busy}), 64'd0);

      // mode change mid-frame, checker then ramp
      do_reset();
      cb = cap.size();
      mode = 2'd0; en = 1'b1;
      tick(121);
      mode = 2'd2;
      wait_fc(16'd1, 300);
      cb1 = cap.size();
      check("f0 bytes", 64'(cb1 - cb), 64'd128);
      check("f0 last line", {16'h0, cap[cb+96], cap[cb+97],
            cap[cb+98], cap[cb+99], cap[cb+100], cap[cb+101]},
            64'hFFFF_FFFF_FFE0);
      wait_fc(16'd2, 300);
      bad = 0;
      for (int i = cb1; i < cb1 + 32; i++)
         if (cap[i] != 8'h00) bad++;
      check("checker line0", 64'(bad), 64'd0);
      mode = 2'd1;
      wait_fc(16'd3, 300);
      cb3 = cap.size();
      wait_fc(16'd4, 300);
      check("ramp x2 y1", 64'({cap[cb3+36], cap[cb3+37]}), 64'h6);
      check("ramp x0 y0", 64'({cap[cb3], cap[cb3+1]}), 64'h3);
      en = 1'b0;
      wait_idle(400, n);

      // asynchronous reset in the middle of an active line
      do_reset();
      mode = 2'd0; en = 1'b1;
      tick(83);
      check("href before rst", 64'(cam_href), 64'd1);
      do_reset();
      vb = vs_total;
      tick(252);
      check("fc restart", 64'(frame_cnt), 64'd0);
      tick(1);
      check("fc after rst frame", 64'(frame_cnt), 64'd1);
      check("vsync after rst", 64'(vs_total - vb), 64'd36);
      en = 1'b0;
      wait_idle(400, n);

      // randomized run/mode/colour traffic
      for (int i = 0; i < 2500; i++) begin
         tick(1);
         if ($urandom_range(63) == 0) en = ~en;
         if ($urandom_range(31) == 0) mode = 2'($urandom_range(3));
         if ($urandom_range(31) == 0) solid_color = 16'($urandom);
      end
      en = 1'b0;
      wait_idle(400, n);
      tick(4);
      check("data zero off href", 64'(nz_idle), 64'd0);
      done = 1;
   endtask

   initial begin
      fork
         monitor();
         stimulus();
      join
      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cmos_pattern_src.md
Name: cmos_pattern_src

Overview:
Synthetic OV5640-style DVP transmitter. It drives cam_vsync, cam_href and cam_data byte streams (RGB565, two bytes per pixel) with programmable timing and test patterns. It replaces the real sensor at the input of the camera capture path, so the capture, SDRAM frame-buffer and HDMI chain can be brought up and regressed without a camera. It is the transmitting end of the interface that ov5640_dri receives.

Parameters:
H_ACTIVE, 1024, active pixels per line (multiple of 8)
V_ACTIVE, 768, active lines per frame
H_BLANK, 64, href-low byte clocks after each line's active bytes (>=1)
V_SYNC, 4, lines with vsync high at frame start (>=1)
V_BP, 16, blank lines after vsync, before first active line
V_FP, 8, blank lines after last active line

Ports:
clk  in  1  pixel byte clock; all logic in this domain
rst_n  in  1  asynchronous active-low reset
en  in  1  run request; level-sensitive
mode  in  2  pattern select, sampled at frame start
solid_color  in  16  RGB565 value for mode 3, sampled at frame start
cam_vsync  out  1  frame sync, active high
cam_href  out  1  line valid, high during active bytes
cam_data  out  8  pixel byte, high byte of RGB565 first
frame_cnt  out  16  completed-frame counter, wraps
busy  out  1  frame in progress

Behaviour:
- Geometry: LINE_LEN = 2*H_ACTIVE + H_BLANK clocks. FRAME_LINES = V_SYNC + V_BP + V_ACTIVE + V_FP.
- Counters: h_cnt runs 0..LINE_LEN-1. v_cnt runs 0..FRAME_LINES-1 and increments when h_cnt wraps.
- FSM has two states, IDLE and RUN.
  - IDLE: counters held at 0; all outputs low except frame_cnt.
  - IDLE->RUN when en=1. h_cnt=v_cnt=0 on the first RUN cycle. mode and solid_color are latched on that cycle.
  - RUN, at the end of a frame (h_cnt=LINE_LEN-1, v_cnt=FRAME_LINES-1):
    - frame_cnt increments.
    - If en=1, the next frame starts immediately and mode/solid_color are relatched.
    - If en=0, go to IDLE.
  - Deasserting en mid-frame never truncates the frame. The current frame always completes.
- Timing decode, one-cycle registered latency from counters to pins:
  - cam_vsync=1 when v_cnt<V_SYNC.
  - cam_href=1 when v_cnt is in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE) and h_cnt<2*H_ACTIVE.
  - cam_data=0 whenever cam_href=0.
- Pixel coordinates: x = h_cnt>>1 and y = v_cnt-(V_SYNC+V_BP), both valid only during href. Even h_cnt emits pix[15:8]; odd h_cnt emits pix[7:0].
- Patterns:
  - mode 0, colour bars: 8 bars of width H_ACTIVE/8, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000. Bar index comes from a bar-width down-counter, not a divider.
  - mode 1, ramp: pix = (x + y + frame_cnt) mod 2^16.
  - mode 2, checker: pix = FFFF if x[5]^y[5], else 0000.
  - mode 3, solid: pix = latched solid_color.
- busy=1 in RUN.
- Reset (async assert, any point including mid-line): state=IDLE, counters=0, cam_vsync=0, cam_href=0, cam_data=0, frame_cnt=0, busy=0. Release is treated as synchronous by the design's reset synchroniser upstream.
- An en pulse of one cycle while IDLE produces exactly one full frame.

Decomposition:
- Shared package holds:
  - RGB565 colour-bar constants (8 x 16 bit)
  - mode encodings MODE_BARS=0, MODE_RAMP=1, MODE_CHECK=2, MODE_SOLID=3
  - LINE_LEN/FRAME_LINES localparam derivations
- One natural sub-module: cmos_pattern_pix. It is combinational plus the bar counter, maps (x, y, frame_cnt, mode, solid) to a 16-bit pix, and is registered by the parent.
- Timing counters and the FSM stay in cmos_pattern_src.

Test Plan:
- Bench params H_ACTIVE=16, V_ACTIVE=4, H_BLANK=4, V_SYNC=1, V_BP=1, V_FP=1 (LINE_LEN=36, 7 lines, 252 clocks/frame).
- Reset, then en=1 with mode=0:
  - cam_vsync high for exactly 36 clocks.
  - 4 href pulses of 32 clocks each, separated by 4 low clocks.
  - First active bytes FF,FF,FF,FF, then FF,E0 at pixel 2; last pixel bytes 00,00.
  - frame_cnt=1 after 252 clocks.
- mode=3, solid_color=16'hA55A:
  - Every active byte pair is A5,5A.
  - 128 active bytes per frame.
  - cam_data=0 whenever href=0.
- en deasserted at clock 100 of frame 0:
  - Frame completes to clock 252; then busy=0 and outputs stay low.
  - frame_cnt=1; no further vsync appears.
- mode changed from 0 to 2 mid-frame:
  - Current frame remains colour bars.
  - Next frame line 0 pixels 0..15 are all 0000.
  - mode=1 on frame 3 gives pixel (x=2, y=1) = 0x0006.
- rst_n pulsed low mid-line at h_cnt=10:
  - All outputs are 0 in the same cycle.
  - After release with en=1, the next vsync starts a full 252-clock frame and frame_cnt restarts from 0.
